// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and limits for the FIFO write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_wr_arbiter_pkg;

    // Upper bound on the number of producers sharing one write port.
    localparam int ARB_MAX_REQ = 8;

    // ARB_IDLE : no write in flight
    // ARB_ISSUE: a word is on the FIFO write port this cycle
    // ARB_STALL: FIFO throttled, waiting for room
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_STALL = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: first eligible requester at or after ptr, wrapping to 0.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides whether a pick is used.
//
// Ports:
//   eligible  in   NUM_REQ  requesters that may be picked this cycle
//   ptr       in   IDX_W    highest-priority index
//   found     out  1        at least one requester is eligible
//   idx       out  IDX_W    chosen requester (0 when nothing is found)
module fifo_rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // Walk the candidates from farthest to nearest so the nearest hit to
    // ptr is the one left standing.
    always_comb begin
        int cand;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (eligible[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with ack checking.
// Latency: 1 cycle from req to gnt/fifo_wr_en; ack checked 1 cycle after the write.
// Backpressure: stalls on fifo_full, or fifo_almostfull while writing; requesters hold until gnt.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req / req_data           per-requester level request and packed data words
//   gnt / grant_id           one-hot grant pulse and index of the last grant
//   fifo_wr_en/fifo_data_in  FIFO write port
//   fifo_full/almostfull     FIFO status, used for throttling
//   fifo_wr_ack/overflow     FIFO write response, checked one cycle after each write
//   wr_count/drop_count      saturating acked / dropped word counters
//   err_overflow             sticky drop flag
// NUM_REQ is intended to be 2..ARB_MAX_REQ.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int CNT_WIDTH  = 16,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic [IDX_W-1:0]              grant_id,
    output logic [CNT_WIDTH-1:0]          wr_count,
    output logic [CNT_WIDTH-1:0]          drop_count,
    output logic                          err_overflow
);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic                    wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [IDX_W-1:0]        grant_id_q, grant_id_d;
    logic                    ack_pending_q, ack_pending_d;
    logic [CNT_WIDTH-1:0]    wr_count_q, wr_count_d;
    logic [CNT_WIDTH-1:0]    drop_count_q, drop_count_d;
    logic                    err_q, err_d;

    logic [NUM_REQ-1:0]      eligible;
    logic                    throttle;
    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    logic                    take;

    // A requester granted last cycle is masked so it can drop req or
    // refresh its data before being considered again.
    assign eligible = req & ~gnt_q;

    // almostfull only blocks when a write is already going in this cycle:
    // that write consumes the last slot.
    assign throttle = fifo_full | (fifo_almostfull & wr_en_q);

    fifo_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .eligible (eligible),
        .ptr      (ptr_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = '0;
        wr_en_d      = 1'b0;
        data_d       = data_q;
        grant_id_d   = grant_id_q;
        take         = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_found && !throttle) begin
                    take = 1'b1;
                end else if (throttle && (|req)) begin
                    state_d = ARB_STALL;
                end
            end
            ARB_ISSUE: begin
                if (throttle) begin
                    state_d = ARB_STALL;
                end else if (pick_found) begin
                    take = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_STALL: begin
                // Always pass through IDLE: one bubble after a stall.
                if (!throttle) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (take) begin
            state_d    = ARB_ISSUE;
            gnt_d      = NUM_REQ'(1) << pick_idx;
            wr_en_d    = 1'b1;
            data_d     = req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            grant_id_d = pick_idx;
            if (int'(pick_idx) == NUM_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_idx + 1'b1;
            end
        end
    end

    // The FIFO answers one cycle after each write; ack_pending lines up
    // with that response.
    always_comb begin
        ack_pending_d = wr_en_q;
        wr_count_d    = wr_count_q;
        drop_count_d  = drop_count_q;
        err_d         = err_q;
        if (ack_pending_q) begin
            if (fifo_wr_ack && !fifo_overflow) begin
                if (wr_count_q != {CNT_WIDTH{1'b1}}) begin
                    wr_count_d = wr_count_q + 1'b1;
                end
            end else begin
                if (drop_count_q != {CNT_WIDTH{1'b1}}) begin
                    drop_count_d = drop_count_q + 1'b1;
                end
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            ptr_q         <= '0;
            gnt_q         <= '0;
            wr_en_q       <= 1'b0;
            data_q        <= '0;
            grant_id_q    <= '0;
            ack_pending_q <= 1'b0;
            wr_count_q    <= '0;
            drop_count_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            wr_en_q       <= wr_en_d;
            data_q        <= data_d;
            grant_id_q    <= grant_id_d;
            ack_pending_q <= ack_pending_d;
            wr_count_q    <= wr_count_d;
            drop_count_q  <= drop_count_d;
            err_q         <= err_d;
        end
    end

    assign gnt          = gnt_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign grant_id     = grant_id_q;
    assign wr_count     = wr_count_q;
    assign drop_count   = drop_count_q;
    assign err_overflow = err_q;

endmodule
